// File: rtl/alu_muldiv_control.sv
// ---------------------------------------------------------------------------
// alu_muldiv_control
//   ALU control decoder with an RV32M iterative multiply/divide engine.
//   The decoder turns {funct7, ALU_Op, funct3} into a 4-bit ALU operation
//   code; M-extension instructions decode to 4'b1111 and are executed by a
//   radix-2 engine (shift-add multiply, restoring divide on magnitudes) that
//   stalls the single-cycle datapath until its result is ready.
//
//   Latency is fixed: accept cycle (IDLE), WIDTH CALC cycles, one DONE cycle.
//
// Ports
//   clk              core clock, rising edge
//   reset            asynchronous, active-high reset
//   valid_i          instruction on the bus is valid this cycle
//   funct7_i         instruction funct7
//   ALU_Op_i         000 R, 001 I, 010 LUI, 011 ld/st, 100 branch
//   funct3_i         instruction funct3
//   rs1_i            operand A (multiplicand / dividend)
//   rs2_i            operand B (multiplier / divisor)
//   ALU_Operation_o  ALU operation code (combinational)
//   stall_o          hold PC and register-file writes
//   md_busy_o        engine computing
//   md_done_o        md_result_o valid (one-cycle pulse)
//   md_result_o      M-extension result, held until the next accept
// ---------------------------------------------------------------------------
module alu_muldiv_control #(
    parameter int WIDTH     = 32,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [6:0]       funct7_i,
    input  logic [2:0]       ALU_Op_i,
    input  logic [2:0]       funct3_i,
    input  logic [WIDTH-1:0] rs1_i,
    input  logic [WIDTH-1:0] rs2_i,
    output logic [3:0]       ALU_Operation_o,
    output logic             stall_o,
    output logic             md_busy_o,
    output logic             md_done_o,
    output logic [WIDTH-1:0] md_result_o
);

    localparam int            CW     = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
    localparam logic [6:0]    F7_ALT = 7'b0100000;
    localparam logic [6:0]    F7_M   = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] hi_q, hi_d;       // product high half / partial remainder
    logic [WIDTH-1:0] lo_q, lo_d;       // multiplier / dividend shifting into quotient
    logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic [2:0]       f3_q, f3_d;
    logic             neg_q, neg_d;     // negate the selected result at the end
    logic [WIDTH-1:0] result_q, result_d;

    // -----------------------------------------------------------------------
    // Decode
    // -----------------------------------------------------------------------
    logic m_enc;
    logic m_op;

    assign m_enc = (ALU_Op_i == 3'b000) && (funct7_i == F7_M);
    assign m_op  = MULDIV_EN && m_enc;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statements can leave it unassigned and infer a latch.
    always_comb begin
        ALU_Operation_o = 4'b0000;
        case (ALU_Op_i)
            3'b000, 3'b001: begin
                case (funct3_i)
                    // SUB exists only for register-register; ADDI ignores funct7.
                    3'b000:  ALU_Operation_o = (ALU_Op_i == 3'b000 && funct7_i == F7_ALT)
                                               ? 4'b0001 : 4'b0000;
                    3'b001:  ALU_Operation_o = 4'b0101;
                    3'b010:  ALU_Operation_o = 4'b1010;
                    3'b011:  ALU_Operation_o = 4'b1011;
                    3'b100:  ALU_Operation_o = 4'b0010;
                    3'b101:  ALU_Operation_o = (funct7_i == F7_ALT) ? 4'b0110 : 4'b0111;
                    3'b110:  ALU_Operation_o = 4'b0011;
                    default: ALU_Operation_o = 4'b0100;
                endcase
                // With the engine disabled the M encodings fall back to ADD.
                if (m_enc) begin
                    ALU_Operation_o = m_op ? 4'b1111 : 4'b0000;
                end
            end
            3'b010:  ALU_Operation_o = 4'b1001;
            3'b100:  ALU_Operation_o = 4'b0001;
            default: ALU_Operation_o = 4'b0000;
        endcase
    end

    // -----------------------------------------------------------------------
    // Operand preparation at accept: signs and magnitudes
    // -----------------------------------------------------------------------
    logic             is_div_in;
    logic             a_signed, b_signed;
    logic             a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             neg_in;

    always_comb begin
        is_div_in = funct3_i[2];
        // MUL/MULH/MULHSU treat A as signed; MUL/MULH treat B as signed.
        a_signed  = is_div_in ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11);
        b_signed  = is_div_in ? ~funct3_i[0] : ~funct3_i[1];
        a_neg     = a_signed & rs1_i[WIDTH-1];
        b_neg     = b_signed & rs2_i[WIDTH-1];
        b_zero    = (rs2_i == '0);
        a_mag     = a_neg ? -rs1_i : rs1_i;
        b_mag     = b_neg ? -rs2_i : rs2_i;
        if (!is_div_in) begin
            neg_in = a_neg ^ b_neg;
        end else if (funct3_i[1]) begin
            neg_in = a_neg;                       // remainder takes the dividend's sign
        end else begin
            // Divide by zero must yield all ones, so the quotient is never negated.
            neg_in = (a_neg ^ b_neg) & ~b_zero;
        end
    end

    // -----------------------------------------------------------------------
    // One radix-2 step of the engine
    // -----------------------------------------------------------------------
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_rs;
    logic               div_ok;
    logic [WIDTH-1:0]   div_sub;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH-1:0]   final_res;

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_rs  = {hi_q, lo_q[WIDTH-1]};
        div_ok  = (div_rs >= {1'b0, opnd_q});
        // When the subtraction is kept the true difference is below the divisor,
        // so the low WIDTH bits of the modular difference are exact.
        div_sub = div_rs[WIDTH-1:0] - opnd_q;

        if (f3_q[2]) begin
            step_hi = div_ok ? div_sub : div_rs[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], div_ok};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end

        prod_fix = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        quo_fix  = neg_q ? -step_lo : step_lo;
        rem_fix  = neg_q ? -step_hi : step_hi;

        case (f3_q)
            3'b000:         final_res = prod_fix[WIDTH-1:0];
            3'b001, 3'b010,
            3'b011:         final_res = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101: final_res = quo_fix;
            default:        final_res = rem_fix;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM next state and datapath updates
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (valid_i && m_op) begin
                    state_d  = CALC;
                    count_d  = '0;
                    hi_d     = '0;
                    lo_d     = is_div_in ? a_mag : b_mag;
                    opnd_d   = is_div_in ? b_mag : a_mag;
                    f3_d     = funct3_i;
                    neg_d    = neg_in;
                    result_d = '0;
                end
            end
            CALC: begin
                hi_d    = step_hi;
                lo_d    = step_lo;
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    state_d  = DONE;
                    result_d = final_res;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Stall is gated by reset so it drops the moment reset rises, even while
    // the core is still presenting the M instruction.
    assign stall_o     = ~reset & valid_i & m_op & (state_q != DONE);
    assign md_busy_o   = (state_q == CALC);
    assign md_done_o   = (state_q == DONE);
    assign md_result_o = result_q;

endmodule
